cnn_operand_loader: RTL and testbench

//  Byte-serial front end of the CNN accelerator. Accepts one frame over a valid/ready byte stream:
//  16 input pixels followed by 4 filters x 16 weights, 80 bytes in all. Presents the frame as

---
 rtl/cnn_operand_loader_if.sv | 32 +++
 rtl/cnn_operand_loader.sv | 125 ++++++++++++
 tb/tb_cnn_operand_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_operand_loader_if.sv
// Stream-in / frame-out bundle for the CNN operand loader.
// Latency: n/a (signal bundle only).
// Backpressure: S_Ready throttles the byte stream; Frm_Ack releases a held frame.
// Ports: S_Data/S_Valid/S_Last/S_Ready byte stream; Pix_Flat/Wgt_Flat frame buses;
//        Frm_Valid/Frm_Ack frame handshake; Frame_Err framing-error pulse.
interface cnn_operand_loader_if #(
    parameter int DATA_W = 8,
    parameter int N_IN   = 16,
    parameter int N_FILT = 4
);
    logic [DATA_W-1:0]             S_Data;
    logic                          S_Valid;
    logic                          S_Last;
    logic                          S_Ready;
    logic [N_IN*DATA_W-1:0]        Pix_Flat;
    logic [N_FILT*N_IN*DATA_W-1:0] Wgt_Flat;
    logic                          Frm_Valid;
    logic                          Frm_Ack;
    logic                          Frame_Err;

    // Producer/consumer side: drives the stream and acknowledges frames.
    modport master (
        output S_Data, S_Valid, S_Last, Frm_Ack,
        input  S_Ready, Pix_Flat, Wgt_Flat, Frm_Valid, Frame_Err
    );

    // Loader side.
    modport slave (
        input  S_Data, S_Valid, S_Last, Frm_Ack,
        output S_Ready, Pix_Flat, Wgt_Flat, Frm_Valid, Frame_Err
    );
endinterface

// File: rtl/cnn_operand_loader.sv
// Byte-serial loader: assembles 16 pixels + 4x16 weights into flat buses for the CNN core.
// Latency: Frm_Valid rises one edge after the final beat; best-case frame period FRM_LEN+1.
// Backpressure: S_Ready low while a frame is held, until the cycle after Frm_Ack.
// Ports: Clk, Rst (sync, active-high); bus = slave side of cnn_operand_loader_if.
module cnn_operand_loader #(
    parameter int DATA_W = 8,
    parameter int N_IN   = 16,
    parameter int N_FILT = 4
) (
    input  logic                   Clk,
    input  logic                   Rst,
    cnn_operand_loader_if.slave    bus
);
    localparam int FRM_LEN = N_IN * (1 + N_FILT);
    localparam int CNT_W   = $clog2(FRM_LEN);
    localparam int PIX_W   = N_IN * DATA_W;
    localparam int WGT_W   = N_FILT * N_IN * DATA_W;

    typedef enum logic [1:0] {
        LOAD_IN = 2'd0,
        LOAD_W  = 2'd1,
        HOLD    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [WGT_W-1:0]   wgt_q, wgt_d;
    logic               frm_vld_q, frm_vld_d;
    logic               frame_err_q, frame_err_d;

    logic               s_rdy;
    logic               accept;
    logic               at_end;
    logic               bad_last;
    logic [CNT_W-1:0]   wgt_idx;

    // State register: every flop in the block, including the data buses.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= LOAD_IN;
            cnt_q       <= '0;
            pix_q       <= '0;
            wgt_q       <= '0;
            frm_vld_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pix_q       <= pix_d;
            wgt_q       <= wgt_d;
            frm_vld_q   <= frm_vld_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pix_d       = pix_q;
        wgt_d       = wgt_q;
        frm_vld_d   = frm_vld_q;
        frame_err_d = 1'b0;

        accept   = bus.S_Valid && s_rdy;
        at_end   = (cnt_q == CNT_W'(FRM_LEN - 1));
        // S_Last must coincide exactly with the last beat position.
        bad_last = (bus.S_Last != at_end);
        wgt_idx  = cnt_q - CNT_W'(N_IN);

        // Byte write happens on every accepted beat, including an erroneous one;
        // stale bytes are simply overwritten by the next frame.
        if (accept) begin
            if (cnt_q < CNT_W'(N_IN)) begin
                pix_d[int'(cnt_q)*DATA_W +: DATA_W] = bus.S_Data;
            end else begin
                wgt_d[int'(wgt_idx)*DATA_W +: DATA_W] = bus.S_Data;
            end
        end

        case (state_q)
            LOAD_IN, LOAD_W: begin
                if (accept) begin
                    if (bad_last) begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = LOAD_IN;
                    end else if (at_end) begin
                        frm_vld_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(N_IN - 1)) begin
                            state_d = LOAD_W;
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.Frm_Ack) begin
                    frm_vld_d = 1'b0;
                    state_d   = LOAD_IN;
                end
            end
            default: begin
                state_d = LOAD_IN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: ready is a decode of state only, gated by reset.
    always_comb begin
        s_rdy = ((state_q == LOAD_IN) || (state_q == LOAD_W)) && !Rst;
    end

    assign bus.S_Ready   = s_rdy;
    assign bus.Pix_Flat  = pix_q;
    assign bus.Wgt_Flat  = wgt_q;
    assign bus.Frm_Valid = frm_vld_q;
    assign bus.Frame_Err = frame_err_q;

endmodule

// File: tb/tb_cnn_operand_loader.sv
// Self-checking bench for cnn_operand_loader with a frame-level reference model.
// Latency: n/a.
// Backpressure: exercised via held Frm_Ack and random S_Valid bubbles.
module tb_cnn_operand_loader;
    localparam int DATA_W  = 8;
    localparam int N_IN    = 16;
    localparam int N_FILT  = 4;
    localparam int FRM_LEN = N_IN * (1 + N_FILT);
    localparam int PIX_W   = N_IN * DATA_W;
    localparam int WGT_W   = N_FILT * N_IN * DATA_W;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    cnn_operand_loader_if #(.DATA_W(DATA_W), .N_IN(N_IN), .N_FILT(N_FILT)) bus ();

    cnn_operand_loader #(.DATA_W(DATA_W), .N_IN(N_IN), .N_FILT(N_FILT)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: byte image of the frame buses and position within a frame.
    logic [7:0] mdl_mem [FRM_LEN];
    int         mdl_pos;
    bit         mdl_hold;
    bit         mdl_err;

    function automatic void model_reset();
        for (int i = 0; i < FRM_LEN; i++) mdl_mem[i] = 8'h00;
        mdl_pos  = 0;
        mdl_hold = 1'b0;
        mdl_err  = 1'b0;
    endfunction

    function automatic void model_accept(input logic [7:0] d, input logic last);
        bit final_pos;
        final_pos = (mdl_pos == FRM_LEN - 1);
        mdl_err = 1'b0;
        mdl_mem[mdl_pos] = d;
        if (last != final_pos) begin
            mdl_err = 1'b1;
            mdl_pos = 0;
        end else if (final_pos) begin
            mdl_hold = 1'b1;
            mdl_pos  = 0;
        end else begin
            mdl_pos++;
        end
    endfunction

    function automatic logic [PIX_W-1:0] exp_pix();
        logic [PIX_W-1:0] r;
        for (int k = 0; k < N_IN; k++) r[k*8 +: 8] = mdl_mem[k];
        return r;
    endfunction

    function automatic logic [WGT_W-1:0] exp_wgt();
        logic [WGT_W-1:0] r;
        for (int i = 0; i < N_FILT*N_IN; i++) r[i*8 +: 8] = mdl_mem[N_IN + i];
        return r;
    endfunction

    task automatic idle(input int n);
        bus.S_Valid = 1'b0;
        bus.S_Last  = 1'b0;
        bus.S_Data  = 8'($urandom);
        repeat (n) begin
            @(posedge Clk); #1;
        end
    endtask

    // Offer one beat and wait (bounded) until it is taken.
    task automatic beat(input logic [7:0] d, input logic last);
        int budget;
        budget = 0;
        bus.S_Valid = 1'b1;
        bus.S_Data  = d;
        bus.S_Last  = last;
        while (!bus.S_Ready && budget < 100) begin
            @(posedge Clk); #1;
            budget++;
        end
        if (!bus.S_Ready) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout S_Ready=%0b required=1", bus.S_Ready);
        end else begin
            @(posedge Clk); #1;
            model_accept(d, last);
        end
        bus.S_Valid = 1'b0;
        bus.S_Last  = 1'b0;
    endtask

    // Send n beats (mode 0: data = index+1, else random); S_Last on beat n-1 if requested.
    task automatic send_beats(input int mode, input int gap_pct, input int n, input bit last_on_final);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) idle(1 + $urandom_range(2));
            d = (mode == 0) ? 8'(i + 1) : 8'($urandom);
            beat(d, last_on_final && (i == n - 1));
        end
    endtask

    task automatic ack();
        bus.Frm_Ack = 1'b1;
        @(posedge Clk); #1;
        bus.Frm_Ack = 1'b0;
        mdl_hold = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        bus.S_Valid = 1'b1;
        bus.S_Last  = 1'b0;
        bus.Frm_Ack = 1'b0;
        repeat (2) begin
            bus.S_Data = 8'($urandom);
            @(posedge Clk); #1;
            checks++;
            if (bus.S_Ready !== 1'b0) begin
                errors++; $display("FAIL rst_ready got=%0b exp=0", bus.S_Ready);
            end
            checks++;
            if ({bus.Frm_Valid, bus.Frame_Err} !== 2'b00) begin
                errors++; $display("FAIL rst_flags got=%b exp=00", {bus.Frm_Valid, bus.Frame_Err});
            end
            checks++;
            if (bus.Pix_Flat !== '0 || bus.Wgt_Flat !== '0) begin
                errors++; $display("FAIL rst_buses got pix=%h exp=0", bus.Pix_Flat);
            end
        end
        bus.S_Valid = 1'b0;
        Rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.S_Ready !== 1'b1) begin
            errors++; $display("FAIL rst_release_ready got=%0b exp=1", bus.S_Ready);
        end
    endtask

    task automatic test_full_frame();
        logic [PIX_W-1:0] cp;
        logic [WGT_W-1:0] cw;
        for (int k = 0; k < N_IN; k++) cp[k*8 +: 8] = 8'(k + 1);
        for (int f = 0; f < N_FILT; f++)
            for (int j = 0; j < N_IN; j++) cw[(f*N_IN + j)*8 +: 8] = 8'(17 + 16*f + j);
        send_beats(0, 0, FRM_LEN, 1'b1);
        checks++;
        if (bus.Frm_Valid !== 1'b1 || bus.Frame_Err !== 1'b0) begin
            errors++; $display("FAIL full_flags got vld=%0b err=%0b exp vld=1 err=0", bus.Frm_Valid, bus.Frame_Err);
        end
        checks++;
        if (bus.Pix_Flat !== cp) begin
            errors++; $display("FAIL full_pix got=%h exp=%h", bus.Pix_Flat, cp);
        end
        checks++;
        if (bus.Wgt_Flat !== cw) begin
            errors++; $display("FAIL full_wgt got=%h exp=%h", bus.Wgt_Flat, cw);
        end
        checks++;
        if (bus.S_Ready !== 1'b0) begin
            errors++; $display("FAIL full_hold_ready got=%0b exp=0", bus.S_Ready);
        end
        idle(3);
        bus.Frm_Ack = 1'b1;
        #1;
        checks++;
        if (bus.S_Ready !== 1'b0) begin
            errors++; $display("FAIL full_ack_cycle_ready got=%0b exp=0", bus.S_Ready);
        end
        @(posedge Clk); #1;
        bus.Frm_Ack = 1'b0;
        mdl_hold = 1'b0;
        checks++;
        if (bus.Frm_Valid !== 1'b0 || bus.S_Ready !== 1'b1) begin
            errors++; $display("FAIL full_after_ack got vld=%0b rdy=%0b exp vld=0 rdy=1", bus.Frm_Valid, bus.S_Ready);
        end
        checks++;
        if (bus.Pix_Flat !== cp) begin
            errors++; $display("FAIL full_pix_after_ack got=%h exp=%h", bus.Pix_Flat, cp);
        end
    endtask

    task automatic test_back_pressure();
        logic [PIX_W-1:0] sp;
        logic [WGT_W-1:0] sw;
        send_beats(1, 0, FRM_LEN, 1'b1);
        sp = exp_pix();
        sw = exp_wgt();
        checks++;
        if (bus.Frm_Valid !== 1'b1) begin
            errors++; $display("FAIL bp_vld got=%0b exp=1", bus.Frm_Valid);
        end
        for (int c = 0; c < 20; c++) begin
            bus.S_Valid = 1'b1;
            bus.S_Data  = 8'($urandom);
            bus.S_Last  = 1'($urandom);
            @(posedge Clk); #1;
            checks++;
            if (bus.S_Ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready cycle=%0d got=%0b exp=0", c, bus.S_Ready);
            end
            checks++;
            if (bus.Pix_Flat !== sp) begin
                errors++; $display("FAIL bp_pix cycle=%0d got=%h exp=%h", c, bus.Pix_Flat, sp);
            end
            checks++;
            if (bus.Wgt_Flat !== sw || bus.Frm_Valid !== 1'b1) begin
                errors++; $display("FAIL bp_wgt cycle=%0d got vld=%0b exp vld=1", c, bus.Frm_Valid);
            end
        end
        idle(0);
        ack();
        send_beats(1, 0, FRM_LEN, 1'b1);
        checks++;
        if (bus.Frm_Valid !== 1'b1) begin
            errors++; $display("FAIL bp_f2_vld got=%0b exp=1", bus.Frm_Valid);
        end
        checks++;
        if (bus.Pix_Flat !== exp_pix() || bus.Wgt_Flat !== exp_wgt()) begin
            errors++; $display("FAIL bp_f2_data got pix=%h exp=%h", bus.Pix_Flat, exp_pix());
        end
        ack();
    endtask

    task automatic test_early_last();
        send_beats(1, 0, 40, 1'b1);
        checks++;
        if (bus.Frame_Err !== mdl_err || bus.Frm_Valid !== 1'b0) begin
            errors++; $display("FAIL early_err got err=%0b vld=%0b exp err=%0b vld=0", bus.Frame_Err, bus.Frm_Valid, mdl_err);
        end
        idle(1);
        checks++;
        if (bus.Frame_Err !== 1'b0) begin
            errors++; $display("FAIL early_err_pulse got=%0b exp=0", bus.Frame_Err);
        end
        send_beats(1, 0, FRM_LEN, 1'b1);
        checks++;
        if (bus.Frm_Valid !== 1'b1 || bus.Frame_Err !== 1'b0) begin
            errors++; $display("FAIL early_recover got vld=%0b err=%0b exp vld=1 err=0", bus.Frm_Valid, bus.Frame_Err);
        end
        checks++;
        if (bus.Pix_Flat !== exp_pix() || bus.Wgt_Flat !== exp_wgt()) begin
            errors++; $display("FAIL early_recover_data got pix=%h exp=%h", bus.Pix_Flat, exp_pix());
        end
        ack();
    endtask

    task automatic test_missing_last();
        logic [7:0] d0;
        send_beats(1, 0, FRM_LEN, 1'b0);
        checks++;
        if (bus.Frame_Err !== mdl_err || bus.Frm_Valid !== 1'b0) begin
            errors++; $display("FAIL miss_err got err=%0b vld=%0b exp err=%0b vld=0", bus.Frame_Err, bus.Frm_Valid, mdl_err);
        end
        d0 = 8'($urandom);
        beat(d0, 1'b0);
        checks++;
        if (bus.Pix_Flat[7:0] !== d0 || bus.Frame_Err !== 1'b0) begin
            errors++; $display("FAIL miss_pix0 got=%h err=%0b exp=%h err=0", bus.Pix_Flat[7:0], bus.Frame_Err, d0);
        end
        for (int i = 1; i < FRM_LEN; i++) beat(8'($urandom), i == FRM_LEN - 1);
        checks++;
        if (bus.Frm_Valid !== 1'b1 || bus.Pix_Flat !== exp_pix() || bus.Wgt_Flat !== exp_wgt()) begin
            errors++; $display("FAIL miss_recover got vld=%0b pix=%h exp pix=%h", bus.Frm_Valid, bus.Pix_Flat, exp_pix());
        end
        ack();
    endtask

    task automatic test_gaps_reset();
        send_beats(1, 50, FRM_LEN, 1'b1);
        checks++;
        if (bus.Frm_Valid !== 1'b1 || bus.Pix_Flat !== exp_pix()) begin
            errors++; $display("FAIL gap_pix got vld=%0b pix=%h exp=%h", bus.Frm_Valid, bus.Pix_Flat, exp_pix());
        end
        checks++;
        if (bus.Wgt_Flat !== exp_wgt()) begin
            errors++; $display("FAIL gap_wgt got=%h exp=%h", bus.Wgt_Flat, exp_wgt());
        end
        ack();
        send_beats(1, 50, 50, 1'b0);
        Rst = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (bus.Frame_Err !== 1'b0 || bus.S_Ready !== 1'b0 || bus.Frm_Valid !== 1'b0) begin
            errors++; $display("FAIL gap_rst got err=%0b rdy=%0b vld=%0b exp 0 0 0", bus.Frame_Err, bus.S_Ready, bus.Frm_Valid);
        end
        checks++;
        if (bus.Pix_Flat !== '0 || bus.Wgt_Flat !== '0) begin
            errors++; $display("FAIL gap_rst_buses got pix=%h exp=0", bus.Pix_Flat);
        end
        Rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.S_Ready !== 1'b1) begin
            errors++; $display("FAIL gap_rst_release got=%0b exp=1", bus.S_Ready);
        end
        send_beats(1, 50, FRM_LEN, 1'b1);
        checks++;
        if (bus.Frm_Valid !== 1'b1 || bus.Frame_Err !== 1'b0) begin
            errors++; $display("FAIL gap_fresh got vld=%0b err=%0b exp vld=1 err=0", bus.Frm_Valid, bus.Frame_Err);
        end
        checks++;
        if (bus.Pix_Flat !== exp_pix() || bus.Wgt_Flat !== exp_wgt()) begin
            errors++; $display("FAIL gap_fresh_data got pix=%h exp=%h", bus.Pix_Flat, exp_pix());
        end
        ack();
    endtask

    initial begin
        Rst         = 1'b1;
        bus.S_Valid = 1'b0;
        bus.S_Last  = 1'b0;
        bus.S_Data  = 8'h00;
        bus.Frm_Ack = 1'b0;
        model_reset();
        test_reset();
        test_full_frame();
        test_back_pressure();
        test_early_last();
        test_missing_last();
        test_gaps_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout elapsed=%0t limit=500000", $time);
        $fatal(1, "watchdog");
    end
endmodule
